// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and default sizes for the SPI master controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_baud_gen.sv
// ============================================================================
// Module      : spi_baud_gen
// Description : One-cycle strobe every (i_div+1) clocks while enabled; the
//               count restarts from zero whenever the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = c_DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == i_div)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == i_div);

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module      : spi_master_ctrl
// Description : Single-word SPI master with SETUP/XFER/HOLD framing, CPOL/CPHA
//               and programmable baud. Define SPI_LSBFE_EN to add lsbfe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DIV_W  = c_DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSBFE_EN
    input  logic              lsbfe,
`endif
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              Data_in,
    output logic              SCK_out,
    output logic              Data_out,
    output logic              SS_master,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int c_CNT_W = $clog2(2*DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_EDGE = c_CNT_W'(2*DATA_W - 1);

    spi_state_t          r_state;
    logic                r_ss;
    logic                r_sck;
    logic                r_dout;
    logic                r_busy;
    logic                r_done;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic [DIV_W-1:0]    r_div;
    logic [c_CNT_W-1:0]  r_edge;
    logic [DATA_W-1:0]   r_tx_sh;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rx_data;
    logic                w_tick;
    logic                w_lsb_in;

`ifdef SPI_LSBFE_EN
    assign w_lsb_in = lsbfe;
`else
    assign w_lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic b, input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    spi_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != IDLE),
        .i_div  (r_div),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ss      <= 1'b1;
            r_sck     <= 1'b0;
            r_dout    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_div     <= '0;
            r_edge    <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sck  <= cpol;
                    r_dout <= 1'b0;
                    if (start) begin
                        r_state <= SETUP;
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_lsb   <= w_lsb_in;
                        r_div   <= baud_div;
                        r_edge  <= '0;
                        r_dout  <= first_bit(tx_data, w_lsb_in);
                        // With cpha=0 the first bit is already on the line, so
                        // the first trailing edge must present the second bit.
                        r_tx_sh <= cpha ? tx_data : shift_out(tx_data, w_lsb_in);
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_edge <= r_edge + 1'b1;
                        // Even edge index is a leading edge.
                        if (r_edge[0] == r_cpha) begin
                            r_rx_sh <= shift_in(r_rx_sh, Data_in, r_lsb);
                        end else begin
                            r_dout  <= first_bit(r_tx_sh, r_lsb);
                            r_tx_sh <= shift_out(r_tx_sh, r_lsb);
                        end
                        if (r_edge == c_LAST_EDGE) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_ss      <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_sh;
                        r_sck     <= r_cpol;
                        r_dout    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (abort && (r_state != IDLE)) begin
                r_state <= IDLE;
                r_ss    <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_sck   <= cpol;
                r_dout  <= 1'b0;
            end
        end
    end

    assign SCK_out   = r_sck;
    assign Data_out  = r_dout;
    assign SS_master = r_ss;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rx_data   = r_rx_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Directed self-checking bench for spi_master_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] tx_data;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] baud_div;
    logic       loop_en;
    logic       din_val;
    wire        Data_in;
    wire        SCK_out;
    wire        Data_out;
    wire        SS_master;
    wire        busy;
    wire        done;
    wire  [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int sck_edges = 0;
    int done_cnt = 0;
    int base_edges;
    int base_done;
    logic sck_prev;

    assign Data_in = loop_en ? Data_out : din_val;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .DATA_W (8),
        .DIV_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .tx_data   (tx_data),
        .cpol      (cpol),
        .cpha      (cpha),
`ifdef SPI_LSBFE_EN
        .lsbfe     (lsbfe),
`endif
        .baud_div  (baud_div),
        .Data_in   (Data_in),
        .SCK_out   (SCK_out),
        .Data_out  (Data_out),
        .SS_master (SS_master),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    always @(negedge clk) begin
        if (SCK_out !== sck_prev) sck_edges++;
        sck_prev = SCK_out;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"},   32'(SS_master), 32'd1);
        check({tag, "_sck"},  32'(SCK_out),   32'd0);
        check({tag, "_dout"}, 32'(Data_out),  32'd0);
        check({tag, "_busy"}, 32'(busy),      32'd0);
        check({tag, "_done"}, 32'(done),      32'd0);
        check({tag, "_rx"},   32'(rx_data),   32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_data = 8'h00;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; baud_div = 8'd0;
        loop_en = 1'b0; din_val = 1'b0;
        tick(3);
        check_reset_outputs("reset");

        // Loopback, mode 0, H=2; start on the first edge after reset release.
        rst = 1'b0; cpol = 1'b0; cpha = 1'b0; baud_div = 8'd1;
        tx_data = 8'hA5; loop_en = 1'b1; start = 1'b1;
        base_edges = sck_edges;
        tick(1);
        start = 1'b0;
        check("m0_busy", 32'(busy), 32'd1);
        check("m0_ss", 32'(SS_master), 32'd0);
        check("m0_first_bit", 32'(Data_out), 32'd1);
        tick(35);
        check("m0_done_early", 32'(done), 32'd0);
        tick(1);
        check("m0_done", 32'(done), 32'd1);
        check("m0_busy_end", 32'(busy), 32'd0);
        check("m0_ss_end", 32'(SS_master), 32'd1);
        check("m0_rx", 32'(rx_data), 32'hA5);
        check("m0_sck_edges", 32'(sck_edges - base_edges), 32'd16);
        tick(1);
        check("m0_done_pulse", 32'(done), 32'd0);

        // Mode 3, H=1, Data_in held high.
        cpol = 1'b1; cpha = 1'b1; baud_div = 8'd0; tx_data = 8'h3C;
        loop_en = 1'b0; din_val = 1'b1;
        tick(1);
        check("m3_sck_idle", 32'(SCK_out), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        check("m3_bit7", 32'(Data_out), 32'd0);
        tick(4);
        check("m3_bit5", 32'(Data_out), 32'd1);
        check("m3_sck_mid", 32'(SCK_out), 32'd0);
        tick(11);
        check("m3_done_early", 32'(done), 32'd0);
        tick(1);
        check("m3_done", 32'(done), 32'd1);
        check("m3_rx", 32'(rx_data), 32'hFF);
        check("m3_sck_end", 32'(SCK_out), 32'd1);

        // Abort during the mode-0 transfer.
        cpol = 1'b0; cpha = 1'b0; baud_div = 8'd1; tx_data = 8'hA5; loop_en = 1'b1;
        tick(1);
        base_done = done_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_ss", 32'(SS_master), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sck", 32'(SCK_out), 32'd0);
        check("abort_rx", 32'(rx_data), 32'hFF);
        tick(40);
        check("abort_no_done", 32'(done_cnt - base_done), 32'd0);

        // start with abort in IDLE starts; extra starts while busy are ignored.
        baud_div = 8'd0;
        base_done = done_cnt;
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd1);
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(40);
        check("single_done", 32'(done_cnt - base_done), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        check("single_rx", 32'(rx_data), 32'hA5);

        // Reset mid-XFER, then a normal transfer.
        cpol = 1'b1; baud_div = 8'd1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick(1);
        rst = 1'b0; cpol = 1'b0; tx_data = 8'h5A; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(35);
        check("post_rst_done_early", 32'(done), 32'd0);
        tick(1);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_rx", 32'(rx_data), 32'h5A);

        // Bit order with tx=0x01.
        lsbfe = 1'b1; tx_data = 8'h01;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
`ifdef SPI_LSBFE_EN
        check("order_first_bit", 32'(Data_out), 32'd1);
`else
        check("order_first_bit", 32'(Data_out), 32'd0);
`endif
        tick(36);
        check("order_done", 32'(done), 32'd1);
        check("order_rx", 32'(rx_data), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the transfer length in bits.
REQ-002 The block SHALL have parameter DIV_W, default 8, meaning the width of baud_div.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  transfer request, sampled only while busy=0.
REQ-006 Port abort  input  1  terminates an active transfer.
REQ-007 Port tx_data  input  DATA_W  word to transmit.
REQ-008 Port cpol, cpha  input  1 each  SPI clock polarity and phase.
REQ-009 Port baud_div  input  DIV_W  SCK half-period minus one, in clk cycles.
REQ-010 Port Data_in  input  1  serial receive bit from the port control logic.
REQ-011 Port SCK_out, Data_out, SS_master  output  1 each  master clock, serial transmit bit, active-low slave select.
REQ-012 Port busy, done  output  1 each  transfer in progress; one-cycle completion pulse.
REQ-013 Port rx_data  output  DATA_W  last completed received word.

Function
REQ-014 The block SHALL implement states IDLE, SETUP, XFER and HOLD; H = baud_div+1 cycles, latched at start.
REQ-015 On start=1 in IDLE, the block SHALL latch tx_data, cpol, cpha and baud_div, and enter SETUP next cycle with SS_master=0 and busy=1.
REQ-016 start while busy=1 SHALL be ignored with no queuing.
REQ-017 SETUP SHALL last H cycles, XFER 2*DATA_W*H cycles (one SCK edge every H cycles), and HOLD H cycles; then IDLE.
REQ-018 On the cycle HOLD exits, the block SHALL set SS_master=1, busy=0, done=1 and update rx_data; rx_data is otherwise stable.
REQ-019 Start-to-done latency SHALL be 1+(2*DATA_W+2)*H cycles.
REQ-020 SCK_out SHALL equal the latched cpol outside XFER; in IDLE it SHALL follow the cpol input, registered.
REQ-021 cpha=0: the first bit SHALL be on Data_out on entering SETUP; Data_in sampled on leading edges, Data_out shifted on trailing edges.
REQ-022 cpha=1: Data_out SHALL shift on leading edges and Data_in be sampled on trailing edges.
REQ-023 Bit order SHALL be MSB first unless REQ-031 applies.
REQ-024 Data_out SHALL be 0 in IDLE.
REQ-025 abort=1 while busy SHALL force IDLE next cycle: SS_master=1, SCK_out=cpol, done=0, rx_data unchanged.
REQ-026 abort in IDLE SHALL be ignored; simultaneous start and abort in IDLE SHALL start a transfer.
REQ-027 The internal bit counter SHALL NOT wrap; XFER exits exactly at edge count 2*DATA_W.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, SS_master=1, SCK_out=0, Data_out=0, busy=0, done=0, rx_data=0, mid-transfer included.
REQ-029 The first start SHALL be honoured on the first clk edge after rst deasserts.

Configuration
REQ-030 Macro SPI_LSBFE_EN SHALL control LSB-first support.
REQ-031 With SPI_LSBFE_EN defined, input port lsbfe (1 bit) SHALL exist; lsbfe=1 latched at start selects LSB-first transmit and receive.
REQ-032 Without SPI_LSBFE_EN, lsbfe SHALL be absent and the order always MSB first.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum spi_state_t and the default DATA_W and DIV_W constants.
REQ-034 Sub-module spi_baud_gen SHALL produce the one-cycle edge strobe every H cycles while enabled, restarting its count on enable.

Verification
REQ-035 baud_div=1, cpol=0, cpha=0, tx=0xA5, Data_in looped to Data_out -> done at cycle 37, rx_data=0xA5, 16 SCK edges.
REQ-036 cpol=1, cpha=1, baud_div=0, tx=0x3C, Data_in=1 -> SCK idles high, done at cycle 19, rx_data=0xFF.
REQ-037 abort at cycle 10 of REQ-035 -> SS_master=1 at cycle 11, no done, rx_data keeps its prior value.
REQ-038 start pulsed while busy -> exactly one transfer and one done pulse.
REQ-039 rst asserted mid-XFER -> outputs at reset values in the same cycle; a new start then completes normally.
REQ-040 With SPI_LSBFE_EN and lsbfe=1, tx=0x01 -> Data_out first bit is 1, and loopback rx_data=0x01.
